da_filter_core: RTL and testbench
=================================

Name: da_filter_core

Overview:
Distributed-arithmetic FIR engine that answers the controller's `start_DA` / `global_valid_out` handshake. The controller starts it with a one-cycle start pulse and a snapshot of the FIFO tap samples. The core loads coefficients on `cload`, builds a 2^TAPS partial-sum LUT, then computes one filter output bit-serially over DATA_W cycles and pulses `valid_out` with the result.

Parameters:
- TAPS, 4, number of filter taps / FIFO sample words (2..6)
- DATA_W, 8, signed sample width (two's complement)
- COEF_W, 8, signed coefficient width
- OUT_W, 16, width of output `y`; must be <= ACC_W
- ACC_W (localparam), DATA_W+COEF_W+clog2(TAPS), internal accumulator width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cload  in  1  coefficient load enable; one coefficient accepted per cycle while high
- coef_in  in  COEF_W  coefficient word; tap 0 first
- start  in  1  one-cycle compute request (from `start_DA`)
- samples  in  TAPS*DATA_W  tap k at bits [k*DATA_W +: DATA_W]
- lut_ready  out  1  LUT valid; starts accepted only when high
- busy  out  1  high in LOAD, BUILD, COMPUTE
- valid_out  out  1  one-cycle pulse, `y` valid
- y  out  OUT_W  signed filter output, held until next valid_out

Behaviour:
- Reset: state=IDLE, lut_ready=0, busy=0, valid_out=0, y=0, coefficient regs=0, LUT=0, counters=0. Reset mid-LOAD/BUILD/COMPUTE aborts immediately; no valid_out is produced.
- States: IDLE, LOAD, BUILD, COMPUTE.
- IDLE with cload=1: capture coef_in as tap 0, set coef count=1, clear lut_ready, go to LOAD.
- Start/cload priority: cload has priority over start in the same IDLE cycle; that start is dropped.
- LOAD: each cycle with cload=1 captures the next tap.
  - When count reaches TAPS, go to BUILD and ignore cload.
  - If cload drops before TAPS words, discard, go to IDLE, lut_ready stays 0.
- BUILD: one LUT entry per cycle, j = 0..2^TAPS-1.
  - LUT[j] = sign-extended sum of c_k over all bits k set in j; width COEF_W+clog2(TAPS).
  - After entry 2^TAPS-1, set lut_ready=1 and go to IDLE.
  - BUILD takes exactly 2^TAPS cycles.
- Start acceptance: start is accepted only in IDLE with lut_ready=1 and cload=0. Otherwise it is ignored; no queueing and no error.
  - On acceptance: latch `samples`, acc=0, bit index b=DATA_W-1, go to COMPUTE.
- COMPUTE, one edge per bit, MSB first:
  - addr = {sample_{TAPS-1}[b], ..., sample_0[b]}.
  - At b=DATA_W-1 (sign bit): acc = -LUT[addr].
  - Otherwise: acc = 2*acc + LUT[addr].
  - All arithmetic is signed at ACC_W; the result is exact with no overflow inside ACC_W.
- Completion: on the b=0 edge, write the final value to `y` (per the optional feature), set valid_out=1 for one cycle, go to IDLE.
- Latency and throughput:
  - valid_out rises DATA_W clocks after the start-accept edge.
  - A new start is accepted on the cycle valid_out is high; back-to-back throughput is 1 result per DATA_W+1 cycles.
- cload during COMPUTE is ignored. LUT and coefficients are unchanged while computing.
- `y` keeps its last value through LOAD/BUILD; it is not cleared by a coefficient reload.

Optional Feature:
- Macro: `DA_SATURATE_EN`.
- Defined: if the final acc exceeds the signed OUT_W range, y clamps to 2^(OUT_W-1)-1 or -2^(OUT_W-1); otherwise y = acc.
- Undefined: y = acc[OUT_W-1:0] (plain truncation, wraps). Latency is identical in both builds.

Test Plan:
- Reset then idle, with start pulsed while lut_ready=0 -> lut_ready=0, busy=0, valid_out never asserted, y=0.
- Load coefs 1,2,3,4, then start with samples 10,20,30,40 -> busy 1+? BUILD exactly 16 cycles; lut_ready=1; valid_out pulses 8 clocks after accept; y=300.
- Coefs 127 x4, samples -128 x4 (OUT_W=16) -> exact -65024:
  - with `DA_SATURATE_EN`: y=0x8000.
  - without: y=0x0200.
- Start asserted during COMPUTE, then again on the valid_out cycle -> first extra start ignored; second accepted; next valid_out 9 cycles after previous.
- cload held 2 cycles only (TAPS=4) -> returns to IDLE, lut_ready=0, subsequent start ignored. Then cload and start in the same cycle -> LOAD entered, start dropped.
- reset asserted in mid-COMPUTE (b=3) -> next cycle IDLE, valid_out=0, lut_ready=0; a fresh load and start yields the correct result.

Source files
------------

// File: rtl/da_filter_core_if.sv
// Handshake and data bundle between the FIR controller and da_filter_core.
// master = controller side, slave = filter core side.
interface da_filter_core_if #(
    parameter int TAPS   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16
);
    logic                     cload;
    logic [COEF_W-1:0]        coef_in;
    logic                     start;
    logic [TAPS*DATA_W-1:0]   samples;
    logic                     lut_ready;
    logic                     busy;
    logic                     valid_out;
    logic [OUT_W-1:0]         y;

    modport master (
        output cload, coef_in, start, samples,
        input  lut_ready, busy, valid_out, y
    );

    modport slave (
        input  cload, coef_in, start, samples,
        output lut_ready, busy, valid_out, y
    );
endinterface

// File: rtl/da_filter_core.sv
// Distributed-arithmetic FIR core: coefficient load, LUT build, bit-serial MAC.
// Optional macro DA_SATURATE_EN clamps y to the signed OUT_W range.
module da_filter_core #(
    parameter int TAPS   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    da_filter_core_if.slave  bus
);
    localparam int TW    = $clog2(TAPS);
    localparam int LW    = COEF_W + TW;
    localparam int ACC_W = DATA_W + COEF_W + TW;
    localparam int NLUT  = 1 << TAPS;
    localparam int BW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CW    = $clog2(TAPS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, BUILD, COMPUTE} state_t;

    state_t                    state, state_nx;
    logic signed [COEF_W-1:0]  coef [TAPS];
    logic signed [LW-1:0]      lut  [NLUT];
    logic [DATA_W-1:0]         smp  [TAPS];
    logic [CW-1:0]             cnt;
    logic [TAPS-1:0]           jdx;
    logic [BW-1:0]             bidx;
    logic signed [ACC_W-1:0]   acc;
    logic                      lut_ready_q;
    logic                      valid_q;
    logic [OUT_W-1:0]          y_q;

    logic                      accept;
    logic                      sign_bit;
    logic [TAPS-1:0]           addr;
    logic signed [LW-1:0]      lut_val;
    logic signed [ACC_W-1:0]   lut_ext;
    logic signed [ACC_W-1:0]   acc_nx;
    logic signed [LW-1:0]      build_sum;
    logic [OUT_W-1:0]          y_nx;

    assign accept   = (state == IDLE) && !bus.cload
                    && bus.start && lut_ready_q;
    assign sign_bit = (bidx == BW'(DATA_W - 1));

    // Column of sample bits at the current bit position forms the LUT address.
    always_comb begin
        addr = '0;
        for (int k = 0; k < TAPS; k++) begin
            addr[k] = smp[k][bidx];
        end
    end

    assign lut_val = lut[addr];
    assign lut_ext = {{(ACC_W-LW){lut_val[LW-1]}}, lut_val};
    assign acc_nx  = sign_bit ? -lut_ext : ((acc <<< 1) + lut_ext);

    // Partial sum of the coefficients selected by the bits of the build index.
    always_comb begin
        build_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (jdx[k]) begin
                build_sum = build_sum
                          + {{(LW-COEF_W){coef[k][COEF_W-1]}}, coef[k]};
            end
        end
    end

`ifdef DA_SATURATE_EN
    logic [ACC_W-OUT_W:0] hi;
    assign hi = acc_nx[ACC_W-1:OUT_W-1];

    // Clamp the final sum when it does not fit the signed output width.
    always_comb begin
        y_nx = acc_nx[OUT_W-1:0];
        if (!(&hi || ~|hi)) begin
            y_nx = acc_nx[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign y_nx = acc_nx[OUT_W-1:0];
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state selection; cload wins over start in IDLE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.cload)   state_nx = LOAD;
                else if (accept) state_nx = COMPUTE;
            end
            LOAD: begin
                if (!bus.cload)                  state_nx = IDLE;
                else if (cnt == CW'(TAPS - 1))   state_nx = BUILD;
            end
            BUILD: begin
                if (&jdx) state_nx = IDLE;
            end
            COMPUTE: begin
                if (bidx == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: coefficient capture, LUT fill, bit-serial accumulate, result.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= '0;
                smp[k]  <= '0;
            end
            for (int j = 0; j < NLUT; j++) lut[j] <= '0;
            cnt         <= '0;
            jdx         <= '0;
            bidx        <= '0;
            acc         <= '0;
            lut_ready_q <= 1'b0;
            valid_q     <= 1'b0;
            y_q         <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cload) begin
                        coef[0]     <= bus.coef_in;
                        cnt         <= CW'(1);
                        jdx         <= '0;
                        lut_ready_q <= 1'b0;
                    end else if (accept) begin
                        for (int k = 0; k < TAPS; k++) begin
                            smp[k] <= bus.samples[k*DATA_W +: DATA_W];
                        end
                        acc  <= '0;
                        bidx <= BW'(DATA_W - 1);
                    end
                end
                LOAD: begin
                    if (bus.cload) begin
                        for (int k = 0; k < TAPS; k++) begin
                            if (cnt == CW'(k)) coef[k] <= bus.coef_in;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                BUILD: begin
                    lut[jdx] <= build_sum;
                    jdx      <= jdx + 1'b1;
                    if (&jdx) lut_ready_q <= 1'b1;
                end
                COMPUTE: begin
                    acc  <= acc_nx;
                    bidx <= bidx - 1'b1;
                    if (bidx == '0) begin
                        y_q     <= y_nx;
                        valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.lut_ready = lut_ready_q;
    assign bus.busy      = (state != IDLE);
    assign bus.valid_out = valid_q;
    assign bus.y         = y_q;
endmodule

// File: tb/tb_da_filter_core.sv
// Randomized self-checking bench for da_filter_core.
// Reference: direct convolution sum(c_k * s_k), then wrap or clamp to OUT_W.
module tb_da_filter_core;
    localparam int TAPS   = 4;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int OUT_W  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    da_filter_core_if #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)
    ) bus ();

    da_filter_core #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic signed [COEF_W-1:0] cf [TAPS];
    logic signed [DATA_W-1:0] sm [TAPS];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint model_y();
        longint sum = 0;
        longint r;
        logic [OUT_W-1:0] t;
        longint maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
        longint minv = -(longint'(1) <<< (OUT_W - 1));
        for (int k = 0; k < TAPS; k++) begin
            sum += longint'(cf[k]) * longint'(sm[k]);
        end
        r = sum;
`ifdef DA_SATURATE_EN
        if (sum > maxv) r = maxv;
        else if (sum < minv) r = minv;
`endif
        t = r[OUT_W-1:0];
        return longint'(t);
    endfunction

    task automatic pack_samples();
        for (int k = 0; k < TAPS; k++) begin
            bus.samples[k*DATA_W +: DATA_W] = sm[k];
        end
    endtask

    task automatic no_valid(input string tag, input int n);
        int c = 0;
        repeat (n) begin
            tick();
            if (bus.valid_out) c++;
        end
        check(tag, c, 0);
    endtask

    task automatic load_coefs(input bit with_start);
        int n = 0;
        bus.cload = 1'b1;
        for (int k = 0; k < TAPS; k++) begin
            bus.coef_in = cf[k];
            if (k == 0) bus.start = with_start;
            tick();
            bus.start = 1'b0;
            if (k == 0) begin
                check("load_busy", bus.busy, 1);
                check("load_lut_clr", bus.lut_ready, 0);
            end
        end
        bus.cload = 1'b0;
        check("build_busy", bus.busy, 1);
        while (!bus.lut_ready && n < 100) begin
            tick();
            n++;
        end
        check("build_len", n, 1 << TAPS);
        check("build_idle", bus.busy, 0);
    endtask

    task automatic run_calc(input string tag, input bit noise);
        int n = 0;
        longint exp = model_y();
        pack_samples();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (noise) begin
            bus.cload = 1'b1;
            bus.coef_in = 8'h55;
            tick();
            tick();
            bus.cload = 1'b0;
            n = 2;
        end
        while (!bus.valid_out && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, DATA_W);
        check({tag, "_y"}, longint'(bus.y), exp);
        tick();
        check({tag, "_pulse"}, bus.valid_out, 0);
        check({tag, "_hold"}, longint'(bus.y), exp);
    endtask

    initial begin
        longint exp_a, exp_b;
        int n;
        reset = 1'b1;
        bus.cload = 1'b0;
        bus.coef_in = '0;
        bus.start = 1'b0;
        bus.samples = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_lut_ready", bus.lut_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.valid_out, 0);
        check("rst_y", longint'(bus.y), 0);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        no_valid("start_no_lut", 12);
        check("start_no_lut_busy", bus.busy, 0);
        check("start_no_lut_y", longint'(bus.y), 0);

        for (int k = 0; k < TAPS; k++) begin
            cf[k] = COEF_W'(k + 1);
            sm[k] = DATA_W'(10 * (k + 1));
        end
        load_coefs(1'b0);
        run_calc("basic300", 1'b0);

        for (int k = 0; k < TAPS; k++) begin
            cf[k] = 8'sd127;
            sm[k] = -8'sd128;
        end
        load_coefs(1'b0);
        run_calc("extreme", 1'b0);

        for (int it = 0; it < 24; it++) begin
            if (it % 4 == 0) begin
                for (int k = 0; k < TAPS; k++) cf[k] = COEF_W'($urandom);
                load_coefs(1'b0);
            end
            for (int k = 0; k < TAPS; k++) sm[k] = DATA_W'($urandom);
            run_calc("rand", (it == 5));
        end

        for (int k = 0; k < TAPS; k++) sm[k] = DATA_W'($urandom);
        exp_a = model_y();
        pack_samples();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < TAPS; k++) sm[k] = DATA_W'($urandom);
        exp_b = model_y();
        pack_samples();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 2;
        while (!bus.valid_out && n < 40) begin
            tick();
            n++;
        end
        check("b2b_first_lat", n, DATA_W);
        check("b2b_first_y", longint'(bus.y), exp_a);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.valid_out && n < 40) begin
            tick();
            n++;
        end
        check("b2b_gap", n, DATA_W + 1);
        check("b2b_second_y", longint'(bus.y), exp_b);
        tick();

        bus.cload = 1'b1;
        bus.coef_in = 8'sd3;
        tick();
        tick();
        bus.cload = 1'b0;
        tick();
        check("abort_busy", bus.busy, 0);
        check("abort_lut", bus.lut_ready, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        no_valid("abort_start", 12);

        for (int k = 0; k < TAPS; k++) cf[k] = COEF_W'($urandom);
        load_coefs(1'b0);
        for (int k = 0; k < TAPS; k++) cf[k] = COEF_W'($urandom);
        load_coefs(1'b1);
        for (int k = 0; k < TAPS; k++) sm[k] = DATA_W'($urandom);
        run_calc("prio", 1'b0);

        for (int k = 0; k < TAPS; k++) sm[k] = DATA_W'($urandom);
        pack_samples();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_valid", bus.valid_out, 0);
        check("midrst_lut", bus.lut_ready, 0);
        check("midrst_y", longint'(bus.y), 0);
        no_valid("midrst_quiet", 12);
        for (int k = 0; k < TAPS; k++) cf[k] = COEF_W'($urandom);
        load_coefs(1'b0);
        for (int k = 0; k < TAPS; k++) sm[k] = DATA_W'($urandom);
        run_calc("post_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
